// File: rtl/bank_evict_ctrl.sv
// rtl/bank_evict_ctrl.sv - victim cacheline write-back sequencer
// Walks the DIRTY offsets of an evicted line lowest-first, then pulses done.
module bank_evict_ctrl #(
    parameter int OFFSET_NUM = 4,
    parameter int OFFSET_W   = 2,
    parameter int LINE_ID_W  = 6
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    evict_req_i,
    output logic                    evict_ready_o,
    input  logic [LINE_ID_W-1:0]    evict_line_i,
    input  logic [2*OFFSET_NUM-1:0] evict_status_i,
    output logic                    wb_valid_o,
    input  logic                    wb_ready_i,
    output logic [LINE_ID_W-1:0]    wb_line_o,
    output logic [OFFSET_W-1:0]     wb_offset_o,
    output logic                    evict_done_o,
    output logic [OFFSET_W:0]       wb_cnt_o,
    output logic                    busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WB   = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [OFFSET_W:0] CNT_ONE = 1;

    state_t                  state_q, state_d;
    logic [OFFSET_NUM-1:0]   mask_q, mask_d;
    logic [LINE_ID_W-1:0]    line_q, line_d;
    logic [OFFSET_W:0]       cnt_q, cnt_d;

    logic [OFFSET_NUM-1:0]   dirty_in;
    logic [OFFSET_NUM-1:0]   low_bit;
    logic [OFFSET_W-1:0]     low_idx;

    always_comb begin
        dirty_in = '0;
        for (int k = 0; k < OFFSET_NUM; k++) begin
            dirty_in[k] = (evict_status_i[2*k +: 2] == 2'b10);
        end
    end

    // Scan high to low so the last hit is the lowest pending offset.
    always_comb begin
        low_bit = '0;
        low_idx = '0;
        for (int k = OFFSET_NUM - 1; k >= 0; k--) begin
            if (mask_q[k]) begin
                low_bit    = '0;
                low_bit[k] = 1'b1;
                low_idx    = OFFSET_W'(k);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        mask_d        = mask_q;
        line_d        = line_q;
        cnt_d         = cnt_q;
        evict_ready_o = 1'b0;
        wb_valid_o    = 1'b0;
        evict_done_o  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                evict_ready_o = 1'b1;
                if (evict_req_i) begin
                    line_d  = evict_line_i;
                    mask_d  = dirty_in;
                    cnt_d   = '0;
                    state_d = (dirty_in != '0) ? ST_WB : ST_DONE;
                end
            end
            ST_WB: begin
                wb_valid_o = 1'b1;
                if (wb_ready_i) begin
                    mask_d = mask_q & ~low_bit;
                    cnt_d  = cnt_q + CNT_ONE;
                    if ((mask_q & ~low_bit) == '0) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                evict_done_o = 1'b1;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            mask_q  <= '0;
            line_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            line_q  <= line_d;
            cnt_q   <= cnt_d;
        end
    end

    assign wb_line_o   = line_q;
    assign wb_offset_o = low_idx;
    assign wb_cnt_o    = cnt_q;
    assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bank_evict_ctrl.sv
// tb/tb_bank_evict_ctrl.sv - directed vector bench for bank_evict_ctrl
module tb_bank_evict_ctrl;

    logic       clk;
    logic       rst;
    logic       evict_req;
    logic       evict_ready;
    logic [5:0] evict_line;
    logic [7:0] evict_status;
    logic       wb_valid;
    logic       wb_ready;
    logic [5:0] wb_line;
    logic [1:0] wb_offset;
    logic       evict_done;
    logic [2:0] wb_cnt;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    bank_evict_ctrl #(.OFFSET_NUM(4), .OFFSET_W(2), .LINE_ID_W(6)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .evict_req_i    (evict_req),
        .evict_ready_o  (evict_ready),
        .evict_line_i   (evict_line),
        .evict_status_i (evict_status),
        .wb_valid_o     (wb_valid),
        .wb_ready_i     (wb_ready),
        .wb_line_o      (wb_line),
        .wb_offset_o    (wb_offset),
        .evict_done_o   (evict_done),
        .wb_cnt_o       (wb_cnt),
        .busy_o         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       req;
        logic [5:0] line;
        logic [7:0] status;
        logic       rdy;
        logic       e_ready;
        logic       e_valid;
        logic       e_done;
        logic       e_busy;
        logic [2:0] e_cnt;
        logic       chk_lo;
        logic [5:0] e_line;
        logic [1:0] e_off;
    } vec_t;

    vec_t vt[14];

    function automatic vec_t mk(logic req, logic [5:0] line, logic [7:0] status, logic rdy,
                                logic e_ready, logic e_valid, logic e_done, logic e_busy,
                                logic [2:0] e_cnt, logic chk_lo, logic [5:0] e_line,
                                logic [1:0] e_off);
        vec_t v;
        v.req = req; v.line = line; v.status = status; v.rdy = rdy;
        v.e_ready = e_ready; v.e_valid = e_valid; v.e_done = e_done; v.e_busy = e_busy;
        v.e_cnt = e_cnt; v.chk_lo = chk_lo; v.e_line = e_line; v.e_off = e_off;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [5:0] line, input logic [7:0] status);
        evict_req    = 1'b1;
        evict_line   = line;
        evict_status = status;
        #1;
        chk("accept_ready", evict_ready, 1);
        step();
        evict_req = 1'b0;
    endtask

    int done_seen;

    initial begin
        rst          = 1'b1;
        evict_req    = 1'b0;
        evict_line   = '0;
        evict_status = '0;
        wb_ready     = 1'b0;
        #12;
        chk("rst_ready", evict_ready, 1);
        chk("rst_valid", wb_valid, 0);
        chk("rst_done",  evict_done, 0);
        chk("rst_busy",  busy, 0);
        chk("rst_cnt",   wb_cnt, 0);
        chk("rst_line",  wb_line, 0);
        chk("rst_off",   wb_offset, 0);
        rst = 1'b0;
        step();

        // No-dirty line, two-offset write-back, 2'b11 code plus ignored requests
        vt[0]  = mk(0, 6'h00, 8'h00,          0, 1, 0, 0, 0, 3'd0, 1, 6'h00, 2'd0);
        vt[1]  = mk(1, 6'h05, 8'b00_01_00_01, 0, 1, 0, 0, 0, 3'd0, 0, 6'h00, 2'd0);
        vt[2]  = mk(0, 6'h00, 8'h00,          0, 0, 0, 1, 1, 3'd0, 0, 6'h00, 2'd0);
        vt[3]  = mk(0, 6'h00, 8'h00,          0, 1, 0, 0, 0, 3'd0, 0, 6'h00, 2'd0);
        vt[4]  = mk(1, 6'h2A, 8'b10_01_10_00, 1, 1, 0, 0, 0, 3'd0, 0, 6'h00, 2'd0);
        vt[5]  = mk(0, 6'h00, 8'h00,          1, 0, 1, 0, 1, 3'd0, 1, 6'h2A, 2'd1);
        vt[6]  = mk(0, 6'h00, 8'h00,          1, 0, 1, 0, 1, 3'd1, 1, 6'h2A, 2'd3);
        vt[7]  = mk(0, 6'h00, 8'h00,          1, 0, 0, 1, 1, 3'd2, 0, 6'h00, 2'd0);
        vt[8]  = mk(0, 6'h00, 8'h00,          0, 1, 0, 0, 0, 3'd2, 0, 6'h00, 2'd0);
        vt[9]  = mk(1, 6'h11, 8'b00_11_00_10, 0, 1, 0, 0, 0, 3'd2, 0, 6'h00, 2'd0);
        vt[10] = mk(1, 6'h3F, 8'hAA,          0, 0, 1, 0, 1, 3'd0, 1, 6'h11, 2'd0);
        vt[11] = mk(1, 6'h3F, 8'hAA,          1, 0, 1, 0, 1, 3'd0, 1, 6'h11, 2'd0);
        vt[12] = mk(1, 6'h3F, 8'hAA,          1, 0, 0, 1, 1, 3'd1, 0, 6'h00, 2'd0);
        vt[13] = mk(0, 6'h00, 8'h00,          0, 1, 0, 0, 0, 3'd1, 0, 6'h00, 2'd0);

        for (int i = 0; i < 14; i++) begin
            evict_req    = vt[i].req;
            evict_line   = vt[i].line;
            evict_status = vt[i].status;
            wb_ready     = vt[i].rdy;
            #1;
            chk($sformatf("v%0d_ready", i), evict_ready, vt[i].e_ready);
            chk($sformatf("v%0d_valid", i), wb_valid,    vt[i].e_valid);
            chk($sformatf("v%0d_done",  i), evict_done,  vt[i].e_done);
            chk($sformatf("v%0d_busy",  i), busy,        vt[i].e_busy);
            chk($sformatf("v%0d_cnt",   i), wb_cnt,      vt[i].e_cnt);
            if (vt[i].chk_lo) begin
                chk($sformatf("v%0d_line", i), wb_line,   vt[i].e_line);
                chk($sformatf("v%0d_off",  i), wb_offset, vt[i].e_off);
            end
            step();
        end
        evict_req = 1'b0;
        wb_ready  = 1'b0;

        // All dirty with three stall cycles per write-back
        accept(6'h3F, 8'hAA);
        for (int o = 0; o < 4; o++) begin
            for (int s = 0; s < 3; s++) begin
                wb_ready = 1'b0;
                #1;
                chk($sformatf("stall%0d_%0d_valid", o, s), wb_valid, 1);
                chk($sformatf("stall%0d_%0d_off", o, s), wb_offset, o);
                chk($sformatf("stall%0d_%0d_line", o, s), wb_line, 6'h3F);
                chk($sformatf("stall%0d_%0d_cnt", o, s), wb_cnt, o);
                step();
            end
            wb_ready = 1'b1;
            #1;
            chk($sformatf("hs%0d_valid", o), wb_valid, 1);
            chk($sformatf("hs%0d_off", o), wb_offset, o);
            step();
            wb_ready = 1'b0;
        end
        chk("all_done", evict_done, 1);
        chk("all_cnt", wb_cnt, 4);
        step();
        chk("all_idle", evict_ready, 1);
        chk("all_cnt_hold", wb_cnt, 4);

        // Request held high: accepts only in IDLE, one done per accept
        done_seen = 0;
        wb_ready  = 1'b1;
        evict_req = 1'b1;
        evict_line = 6'h0C;
        for (int c = 0; c < 20; c++) begin
            evict_status = (c % 5 == 0) ? 8'h02 : 8'h01;
            #1;
            chk($sformatf("hold%0d_ready", c), evict_ready, (c % 5 == 0) || (c % 5 == 3));
            chk($sformatf("hold%0d_done", c), evict_done, (c % 5 == 2) || (c % 5 == 4));
            chk($sformatf("hold%0d_valid", c), wb_valid, (c % 5 == 1));
            if (evict_done) done_seen++;
            step();
        end
        evict_req = 1'b0;
        wb_ready  = 1'b0;
        chk("hold_done_count", done_seen, 8);

        // Asynchronous reset while a write-back is stalled
        accept(6'h07, 8'hAA);
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;
        #1;
        chk("pre_rst_valid", wb_valid, 1);
        chk("pre_rst_cnt", wb_cnt, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", wb_valid, 0);
        chk("mid_rst_ready", evict_ready, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cnt", wb_cnt, 0);
        chk("mid_rst_line", wb_line, 0);
        chk("mid_rst_off", wb_offset, 0);
        #2;
        rst = 1'b0;
        step();
        accept(6'h09, 8'b00_00_00_10);
        wb_ready = 1'b1;
        #1;
        chk("post_rst_valid", wb_valid, 1);
        chk("post_rst_line", wb_line, 6'h09);
        chk("post_rst_off", wb_offset, 0);
        step();
        chk("post_rst_done", evict_done, 1);
        chk("post_rst_cnt", wb_cnt, 1);
        step();
        chk("post_rst_idle", evict_ready, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/bank_evict_ctrl.md
Name: bank_evict_ctrl

Overview:
- Sequences the write-back of a victim cacheline before the bank re-allocates it.
- Accepts an eviction request carrying the line's per-offset 2-bit status vector (EMPTY=2'b00, SYNC=2'b01, DIRTY=2'b10).
- Issues one write-back request per DIRTY offset over a valid/ready handshake, lowest offset first, then pulses done so the allocate can proceed.
- Sits between the bank hit-test unit (which supplies the offset states) and the downstream memory write port.

Parameters:
OFFSET_NUM, 4, number of offsets per cacheline (>=2)
OFFSET_W, 2, offset index width, equals log2(OFFSET_NUM)
LINE_ID_W, 6, cacheline identifier width

Ports:
clk_i  input  1  clock, all state on rising edge
rst_i  input  1  reset, asynchronous, active-high
evict_req_i  input  1  eviction request valid
evict_ready_o  output  1  controller can accept a request (high only in IDLE)
evict_line_i  input  LINE_ID_W  victim line id, captured on accept
evict_status_i  input  2*OFFSET_NUM  offset states, offset k at bits [2k+1:2k], captured on accept
wb_valid_o  output  1  write-back request valid
wb_ready_i  input  1  downstream accepts write-back
wb_line_o  output  LINE_ID_W  line id of current write-back
wb_offset_o  output  OFFSET_W  offset index of current write-back
evict_done_o  output  1  one-cycle pulse: eviction sequence complete
wb_cnt_o  output  OFFSET_W+1  write-backs completed for the current/last eviction
busy_o  output  1  high whenever state != IDLE

Behaviour:
- States: IDLE, WB, DONE. Encoding is free; no other states.
- Reset (async, any time, including mid-sequence): state=IDLE, dirty mask=0, captured line=0, wb_cnt_o=0. Outputs: evict_ready_o=1, wb_valid_o=0, evict_done_o=0, busy_o=0, wb_line_o=0, wb_offset_o=0.
- Accept: evict_req_i & evict_ready_o in cycle T.
  - Capture evict_line_i.
  - Capture dirty mask: bit k = (status[2k+1:2k] == 2'b10). Codes 2'b00, 2'b01 and 2'b11 are not dirty.
  - Clear wb_cnt_o to 0.
  - If mask != 0, go to WB; otherwise go to DONE.
- IDLE: evict_ready_o=1 and busy_o=0. evict_req_i without the handshake leaves all state unchanged.
- WB:
  - wb_valid_o=1, wb_line_o=captured line, wb_offset_o=index of the lowest set mask bit. First wb_valid_o is at T+1.
  - wb_valid_o, wb_line_o and wb_offset_o stay stable while wb_ready_i=0. No timeout.
  - On wb_valid_o & wb_ready_i: clear that mask bit and increment wb_cnt_o.
  - If the remaining mask is 0, go to DONE; otherwise stay in WB and present the next offset in the following cycle. Back-to-back handshakes are allowed, one per cycle.
- DONE: evict_done_o=1 for exactly one cycle, wb_valid_o=0, then go to IDLE.
  - Empty-mask eviction: done pulse at T+1, ready again at T+2.
- No back-to-back acceptance: evict_ready_o=0 in WB and DONE, and evict_req_i is ignored there. Minimum spacing between accepts is 2 cycles (empty mask).
- wb_cnt_o holds its final value after DONE until the next accept; it never exceeds OFFSET_NUM.
- wb_line_o and wb_offset_o hold their last values when wb_valid_o=0. They are don't-care for checking except after reset.
- Latency with N dirty offsets and ready always high: accept at T, done pulse at T+N+1.

Test Plan:
1. Reset mid-WB (assert rst_i while wb_valid_o=1 and wb_ready_i=0) -> same cycle: wb_valid_o=0, evict_ready_o=1, busy_o=0, wb_cnt_o=0; next request is handled normally.
2. Status=8'b00_01_00_01 (no dirty), line=5 -> no wb_valid_o; evict_done_o at T+1; wb_cnt_o=0; evict_ready_o=1 at T+2.
3. Status=8'b10_01_10_00 (offsets 1,3 dirty), line=0x2A, wb_ready_i=1 -> wb (0x2A, offset 1) at T+1, wb (0x2A, offset 3) at T+2, done at T+3, wb_cnt_o=2.
4. All dirty (8'b10101010) with wb_ready_i low for 3 cycles per request -> offsets 0,1,2,3 in order, each held stable while stalled; done after the 4th handshake; wb_cnt_o=4.
5. Status code 2'b11 on offset 2 plus DIRTY on offset 0 -> only offset 0 written back; wb_cnt_o=1.
6. evict_req_i held high continuously with alternating dirty and non-dirty status vectors -> a new accept occurs only in IDLE; no accept during WB or DONE; each accept produces exactly one done pulse.
